// File: rtl/exp2_fixed_point_if.sv
// Streaming bus for the exp2 pipeline: operand side driven by the master,
// result side driven by the exp2 block.
interface exp2_fixed_point_if;
    logic        valid;       // rate enable into the block
    logic        data_valid;  // qualifies data in an enabled cycle
    logic [15:0] data;        // sfix16_En10 operand
    logic        rate_valid;  // rate enable passed downstream
    logic        exp2_valid;
    logic [10:0] exp2;        // ufix11_En10 result
    logic        sat;

    modport master (
        output valid, data_valid, data,
        input  rate_valid, exp2_valid, exp2, sat
    );

    modport slave (
        input  valid, data_valid, data,
        output rate_valid, exp2_valid, exp2, sat
    );
endinterface

// File: rtl/exp2_fixed_point.sv
// Three-stage 2^x for sfix16_En10 x: 32-entry mantissa ROM indexed by the
// top fraction bits, then a right shift by the negated integer part.
module exp2_fixed_point (
    input  logic i_CLK,
    input  logic i_RSTn,
    exp2_fixed_point_if.slave bus
);

    function automatic logic [10:0] mant_rom(input logic [4:0] k);
        logic [10:0] m;
        case (k)
            5'd0:  m = 11'd1024;  5'd1:  m = 11'd1046;  5'd2:  m = 11'd1069;  5'd3:  m = 11'd1093;
            5'd4:  m = 11'd1117;  5'd5:  m = 11'd1141;  5'd6:  m = 11'd1166;  5'd7:  m = 11'd1192;
            5'd8:  m = 11'd1218;  5'd9:  m = 11'd1244;  5'd10: m = 11'd1272;  5'd11: m = 11'd1300;
            5'd12: m = 11'd1328;  5'd13: m = 11'd1357;  5'd14: m = 11'd1387;  5'd15: m = 11'd1417;
            5'd16: m = 11'd1448;  5'd17: m = 11'd1480;  5'd18: m = 11'd1512;  5'd19: m = 11'd1545;
            5'd20: m = 11'd1579;  5'd21: m = 11'd1614;  5'd22: m = 11'd1649;  5'd23: m = 11'd1685;
            5'd24: m = 11'd1722;  5'd25: m = 11'd1760;  5'd26: m = 11'd1798;  5'd27: m = 11'd1838;
            5'd28: m = 11'd1878;  5'd29: m = 11'd1919;  5'd30: m = 11'd1961;  5'd31: m = 11'd2004;
            default: m = 11'd1024;
        endcase
        return m;
    endfunction

    logic signed [5:0] s1_int;
    logic [4:0]        s1_idx;
    logic              s1_vld;
    logic [10:0]       s2_mant;
    logic signed [5:0] s2_int;
    logic              s2_vld;
    logic [10:0]       s3_exp2;
    logic              s3_sat;
    logic              s3_vld;

    logic signed [5:0] shamt;
    logic [10:0]       shifted;
    logic              sat_next;
    logic              unused_frac_lsbs;

    // Fraction bits below the table index carry no weight in the result.
    assign unused_frac_lsbs = ^bus.data[4:0];

    // The integer field is already floor(x), so negative inputs need no fix-up.
    always_comb begin
        shamt    = -s2_int;
        shifted  = '0;
        sat_next = 1'b0;
        if (!s2_int[5] && s2_int != 6'sd0) begin
            shifted  = '1;
            sat_next = 1'b1;
        end else if (s2_int == 6'sd0) begin
            shifted = s2_mant;
        end else if (s2_int >= -6'sd10) begin
            shifted = s2_mant >> shamt;
        end
    end

    always_ff @(posedge i_CLK or negedge i_RSTn) begin
        if (!i_RSTn) begin
            s1_int  <= '0;
            s1_idx  <= '0;
            s1_vld  <= 1'b0;
            s2_mant <= '0;
            s2_int  <= '0;
            s2_vld  <= 1'b0;
            s3_exp2 <= '0;
            s3_sat  <= 1'b0;
            s3_vld  <= 1'b0;
        end else if (bus.valid) begin
            s1_int  <= bus.data[15:10];
            s1_idx  <= bus.data[9:5];
            s1_vld  <= bus.data_valid;
            s2_mant <= mant_rom(s1_idx);
            s2_int  <= s1_int;
            s2_vld  <= s1_vld;
            s3_exp2 <= shifted;
            s3_sat  <= sat_next;
            s3_vld  <= s2_vld;
        end
    end

    assign bus.rate_valid = bus.valid;
    assign bus.exp2_valid = s3_vld;
    assign bus.exp2       = s3_exp2;
    assign bus.sat        = s3_sat;

endmodule

// File: tb/tb_exp2_fixed_point.sv
// Directed and table-driven checks for exp2_fixed_point, plus a full sweep
// of the operand space against a real-arithmetic reference.
module tb_exp2_fixed_point;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    exp2_fixed_point_if bus ();

    exp2_fixed_point dut (
        .i_CLK  (clk),
        .i_RSTn (rstn),
        .bus    (bus)
    );

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [15:0] data;
        logic        dv;
        logic [10:0] exp2;
        logic        sat;
    } vec_t;

    vec_t tab[$];
    int   n_main;

    logic [12:0] obs;
    assign obs = {bus.exp2_valid, bus.sat, bus.exp2};

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", name, got, exp);
        end
    endtask

    task automatic drive(input logic v, input logic dv, input logic [15:0] d);
        bus.valid      = v;
        bus.data_valid = dv;
        bus.data       = d;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic [15:0] d, input logic dv, input int e, input logic s);
        vec_t v;
        v.data = d;
        v.dv   = dv;
        v.exp2 = 11'(e);
        v.sat  = s;
        tab.push_back(v);
    endtask

    function automatic logic [12:0] ref_out(input logic [15:0] d, input logic dv);
        int ip;
        int k;
        int m;
        logic [10:0] e;
        logic s;
        ip = int'($signed(d[15:10]));
        k  = int'(d[9:5]);
        m  = $rtoi(1024.0 * (2.0 ** (real'(k) / 32.0)) + 0.5);
        e  = '0;
        s  = 1'b0;
        if (ip >= 1) begin
            e = 11'h7FF;
            s = 1'b1;
        end else if (ip == 0) begin
            e = 11'(m);
        end else if (ip >= -10) begin
            e = 11'(m >> (-ip));
        end
        return {dv, s, e};
    endfunction

    // Streams rows back-to-back; row j is checked after edge j+2.
    task automatic run_table(input int lo, input int hi, input string tag);
        int n;
        n = hi - lo;
        for (int i = 0; i < n + 2; i++) begin
            if (i < n) drive(1'b1, tab[lo + i].dv, tab[lo + i].data);
            else       drive(1'b1, 1'b0, 16'h0000);
            tick();
            if (i >= 2) begin
                chk($sformatf("%s[%0d] x=0x%04h", tag, lo + i - 2, tab[lo + i - 2].data),
                    16'(obs),
                    16'({tab[lo + i - 2].dv, tab[lo + i - 2].sat, tab[lo + i - 2].exp2}));
            end
        end
    endtask

    initial begin
        add(16'h0000, 1'b1, 1024, 1'b0);
        add(16'h0200, 1'b1, 1448, 1'b0);
        add(16'hFC00, 1'b1,  512, 1'b0);
        add(16'hFE00, 1'b1,  724, 1'b0);
        add(16'h0400, 1'b1, 2047, 1'b1);
        add(16'hD000, 1'b1,    0, 1'b0);
        add(16'h8000, 1'b1,    0, 1'b0);
        add(16'h7FFF, 1'b1, 2047, 1'b1);
        add(16'h03FF, 1'b1, 2004, 1'b0);
        add(16'h0100, 1'b1, 1218, 1'b0);
        add(16'h0020, 1'b1, 1046, 1'b0);
        add(16'hF800, 1'b1,  256, 1'b0);
        add(16'hD800, 1'b1,    1, 1'b0);
        add(16'hD400, 1'b1,    0, 1'b0);
        add(16'hF6FF, 1'b1,  210, 1'b0);
        add(16'hFBE0, 1'b1,  501, 1'b0);
        n_main = tab.size();
        // alternating data_valid; masked slots still carry their data
        add(16'h0000, 1'b1, 1024, 1'b0);
        add(16'h0400, 1'b0, 2047, 1'b1);
        add(16'h0200, 1'b1, 1448, 1'b0);
        add(16'hFC00, 1'b0,  512, 1'b0);
        add(16'hFE00, 1'b1,  724, 1'b0);
        add(16'h0100, 1'b0, 1218, 1'b0);

        // reset state, including clocks while held in reset
        drive(1'b0, 1'b0, 16'h0000);
        #12;
        chk("reset outputs", 16'(obs), 16'h0000);
        drive(1'b1, 1'b1, 16'h0400);
        tick();
        chk("reset held through clock", 16'(obs), 16'h0000);
        rstn = 1'b1;

        run_table(0, n_main, "vec");
        run_table(n_main, tab.size(), "mask");

        // enable gating
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1, 16'h0400);
            tick();
        end
        drive(1'b1, 1'b1, 16'h0200);
        tick();
        chk("gate pre", 16'(obs), 16'h1FFF);
        for (int g = 0; g < 5; g++) begin
            drive(1'b0, g[0], 16'hD000 + 16'(g));
            tick();
            chk($sformatf("gate frozen %0d", g), 16'(obs), 16'h1FFF);
            chk($sformatf("gate o_VALID low %0d", g), 16'(bus.rate_valid), 16'h0000);
        end
        drive(1'b1, 1'b0, 16'h0000);
        #1;
        chk("gate o_VALID high", 16'(bus.rate_valid), 16'h0001);
        tick();
        chk("gate en1", 16'(obs), 16'h1FFF);
        tick();
        chk("gate en2 result", 16'(obs), 16'h15A8);
        tick();
        chk("gate en3 valid", 16'(bus.exp2_valid), 16'h0000);

        // reset mid-stream with two operands in flight
        drive(1'b1, 1'b1, 16'h0400);
        tick();
        tick();
        drive(1'b1, 1'b1, 16'h0200);
        tick();
        chk("pre-reset output", 16'(obs), 16'h1FFF);
        #2;
        rstn = 1'b0;
        #1;
        chk("async reset clears", 16'(obs), 16'h0000);
        tick();
        tick();
        chk("reset holds", 16'(obs), 16'h0000);
        rstn = 1'b1;
        drive(1'b1, 1'b1, 16'h0100);
        tick();
        chk("post-reset c1 valid", 16'(bus.exp2_valid), 16'h0000);
        drive(1'b1, 1'b0, 16'h0000);
        tick();
        chk("post-reset c2 valid", 16'(bus.exp2_valid), 16'h0000);
        tick();
        chk("post-reset c3 result", 16'(obs), 16'h14C2);
        tick();
        chk("post-reset c4 valid", 16'(bus.exp2_valid), 16'h0000);

        // full operand sweep
        for (int i = 0; i < 65538; i++) begin
            if (i < 65536) drive(1'b1, 1'b1, 16'(i));
            else           drive(1'b1, 1'b0, 16'h0000);
            tick();
            if (i >= 2) begin
                chk($sformatf("sweep x=0x%04h", 16'(i - 2)), 16'(obs),
                    16'(ref_out(16'(i - 2), 1'b1)));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
